// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that applies LFSR backpressure and checks a framed counting pattern.
// Per-beat check results are staged one cycle before they reach the counters and sticky flags.
module axis_frame_checker #(
  parameter int          DATA_W      = 32,
  parameter int          KEEP_W      = DATA_W / 8,
  parameter int          USER_W      = 1,
  parameter int          FRAME_BEATS = 8,
  parameter int          BP_EN       = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [31:0]       frame_count,
  output logic [15:0]       error_count,
  output logic              err_data,
  output logic              err_last,
  output logic              err_keep,
  output logic              err_user,
  output logic              err_proto,
  output logic [DATA_W-1:0] err_beat_data,
  output logic              pass
);

  localparam int BW = $clog2(FRAME_BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BEATS - 1);

  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              bp_ok;
  logic [DATA_W-1:0] exp_word;
  logic [BW-1:0]     beat_idx;

  logic              stall_q;
  logic [DATA_W-1:0] prev_tdata;
  logic [KEEP_W-1:0] prev_tkeep;
  logic [USER_W-1:0] prev_tuser;
  logic              prev_tlast;

  logic              accept;
  logic              idx_last;
  logic              c_data, c_keep, c_user, c_last, c_proto;

  // {proto, user, keep, last, data}
  logic [4:0]        st_err;
  logic              st_frame;
  logic [DATA_W-1:0] st_tdata;
  logic [2:0]        st_n;
  logic [16:0]       ec_sum;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign bp_ok    = (BP_EN == 0) | lfsr[0] | lfsr[1];
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign idx_last = (beat_idx == LAST_IDX);

  assign c_data  = accept & (s_axis_tdata != exp_word);
  assign c_keep  = accept & (s_axis_tkeep != {KEEP_W{1'b1}});
  assign c_user  = accept & (s_axis_tuser[0] != (beat_idx == '0));
  assign c_last  = accept & (s_axis_tlast != idx_last);
  assign c_proto = stall_q & (~s_axis_tvalid
                              | (s_axis_tdata != prev_tdata)
                              | (s_axis_tkeep != prev_tkeep)
                              | (s_axis_tuser != prev_tuser)
                              | (s_axis_tlast != prev_tlast));

  assign st_n   = {2'b00, st_err[0]} + {2'b00, st_err[1]} + {2'b00, st_err[2]}
                + {2'b00, st_err[3]} + {2'b00, st_err[4]};
  assign ec_sum = {1'b0, error_count} + {14'b0, st_n};
  assign pass   = (frame_count != 32'd0) && (error_count == 16'd0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      lfsr          <= LFSR_SEED;
      s_axis_tready <= 1'b0;
      exp_word      <= '0;
      beat_idx      <= '0;
      stall_q       <= 1'b0;
      prev_tdata    <= '0;
      prev_tkeep    <= '0;
      prev_tuser    <= '0;
      prev_tlast    <= 1'b0;
      st_err        <= '0;
      st_frame      <= 1'b0;
      st_tdata      <= '0;
      frame_count   <= '0;
      error_count   <= '0;
      err_data      <= 1'b0;
      err_last      <= 1'b0;
      err_keep      <= 1'b0;
      err_user      <= 1'b0;
      err_proto     <= 1'b0;
      err_beat_data <= '0;
    end else begin
      if (enable) lfsr <= {lfsr[14:0], lfsr_fb};
      s_axis_tready <= enable & bp_ok;

      // The word counter never resyncs, so one corrupt word yields exactly one error.
      if (accept) begin
        exp_word <= exp_word + 1'b1;
        beat_idx <= (s_axis_tlast || idx_last) ? '0 : beat_idx + 1'b1;
      end

      stall_q    <= s_axis_tvalid & ~s_axis_tready;
      prev_tdata <= s_axis_tdata;
      prev_tkeep <= s_axis_tkeep;
      prev_tuser <= s_axis_tuser;
      prev_tlast <= s_axis_tlast;

      st_err   <= {c_proto, c_user, c_keep, c_last, c_data};
      st_frame <= accept & s_axis_tlast;
      st_tdata <= s_axis_tdata;

      if (st_frame) frame_count <= frame_count + 32'd1;
      error_count <= ec_sum[16] ? 16'hFFFF : ec_sum[15:0];
      if (st_err[0] && !err_data) err_beat_data <= st_tdata;
      err_data  <= err_data  | st_err[0];
      err_last  <= err_last  | st_err[1];
      err_keep  <= err_keep  | st_err[2];
      err_user  <= err_user  | st_err[3];
      err_proto <= err_proto | st_err[4];
    end
  end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench: two checker instances (backpressure off / on) share one stream driver;
// sel picks which instance the driver honours and which outputs are checked.
module tb_axis_frame_checker;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic [0:0]  tuser;
  logic        tlast;
  logic        tvalid;
  bit          sel;

  logic        tready_nb, tready_bp;
  logic [31:0] fc_nb, fc_bp;
  logic [15:0] ec_nb, ec_bp;
  logic        ed_nb, el_nb, ek_nb, eu_nb, ep_nb, pass_nb;
  logic        ed_bp, el_bp, ek_bp, eu_bp, ep_bp, pass_bp;
  logic [31:0] ebd_nb, ebd_bp;

  logic        tready;
  logic [31:0] fc;
  logic [15:0] ec;
  logic [4:0]  flags;
  logic [31:0] ebd;
  logic        pass;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles;
  bit drop_pending = 0;

  always #5 aclk = ~aclk;

  axis_frame_checker #(.BP_EN(0)) u_nb (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(tready_nb),
    .frame_count(fc_nb), .error_count(ec_nb),
    .err_data(ed_nb), .err_last(el_nb), .err_keep(ek_nb), .err_user(eu_nb),
    .err_proto(ep_nb), .err_beat_data(ebd_nb), .pass(pass_nb));

  axis_frame_checker #(.BP_EN(1)) u_bp (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tvalid(tvalid), .s_axis_tready(tready_bp),
    .frame_count(fc_bp), .error_count(ec_bp),
    .err_data(ed_bp), .err_last(el_bp), .err_keep(ek_bp), .err_user(eu_bp),
    .err_proto(ep_bp), .err_beat_data(ebd_bp), .pass(pass_bp));

  assign tready = sel ? tready_bp : tready_nb;
  assign fc     = sel ? fc_bp : fc_nb;
  assign ec     = sel ? ec_bp : ec_nb;
  assign flags  = sel ? {ep_bp, eu_bp, ek_bp, el_bp, ed_bp} : {ep_nb, eu_nb, ek_nb, el_nb, ed_nb};
  assign ebd    = sel ? ebd_bp : ebd_nb;
  assign pass   = sel ? pass_bp : pass_nb;

  typedef struct {
    bit         sel;
    int         n;
    int         bad_idx;
    int         last_idx;
    int         exp_frames;
    int         exp_errors;
    logic [4:0] exp_flags;   // {proto, user, keep, last, data}
    bit         exp_pass;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; enable = 1'b0; tvalid = 1'b0;
    tdata = '0; tkeep = '1; tuser = '0; tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    repeat (3) @(posedge aclk);
    #1 stall_cycles = 0;
  endtask

  task automatic send(input logic [31:0] d, input bit sof, input bit last);
    int  waited = 0;
    bit  done   = 0;
    tdata = d; tuser = sof; tlast = last; tkeep = '1; tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (tready) begin
        @(posedge aclk);
        #1 done = 1;
      end else begin
        stall_cycles++;
        if (drop_pending) begin
          drop_pending = 0;
          @(posedge aclk);
          #1 tvalid = 1'b0;
          @(posedge aclk);
          #1 tvalid = 1'b1;
        end else begin
          @(posedge aclk);
        end
        waited++;
        if (waited > 50) begin
          n_checks++; n_fail++;
          $display("FAIL beat_timeout: word %0h not accepted within 50 cycles", d);
          done = 1;
        end
      end
    end
  endtask

  task automatic send_stream(input int n, input int bad_idx, input int last_idx);
    int pos = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      bit          l;
      d = (i == bad_idx) ? 32'hDEADBEEF : 32'(i);
      l = (pos == 7) || (i == last_idx);
      send(d, pos == 0, l);
      pos = l ? 0 : pos + 1;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = '0;
  endtask

  task automatic settle();
    repeat (4) @(posedge aclk);
    #1;
  endtask

  initial begin
    tbl[0] = '{0, 24, -1, -1, 3, 0, 5'b00000, 1};  // clean, no backpressure
    tbl[1] = '{0, 16, 10, -1, 2, 1, 5'b00001, 0};  // corrupt word 10
    tbl[2] = '{0, 14, -1,  5, 2, 1, 5'b00010, 0};  // early tlast on beat 5
    tbl[3] = '{0, 12,  3,  3, 2, 2, 5'b00011, 0};  // data + last error on same beat
    tbl[4] = '{1, 32, -1, -1, 4, 0, 5'b00000, 1};  // clean under LFSR backpressure

    sel = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      check("rst_counts", {fc_nb, 16'h0, ec_nb}, 64'h0);
      check("rst_misc", {tready_nb, tready_bp, ed_nb, el_nb, ek_nb, eu_nb, ep_nb, pass_nb,
                         ebd_nb, ed_bp, ep_bp, pass_bp, fc_bp[15:0]}, 64'h0);
    end

    for (int v = 0; v < 5; v++) begin
      sel = tbl[v].sel;
      do_reset();
      start();
      send_stream(tbl[v].n, tbl[v].bad_idx, tbl[v].last_idx);
      settle();
      check($sformatf("v%0d frame_count", v), fc, 64'(tbl[v].exp_frames));
      check($sformatf("v%0d error_count", v), ec, 64'(tbl[v].exp_errors));
      check($sformatf("v%0d flags", v), flags, tbl[v].exp_flags);
      check($sformatf("v%0d pass", v), pass, tbl[v].exp_pass);
      check($sformatf("v%0d err_beat_data", v), ebd,
            tbl[v].exp_flags[0] ? 64'hDEADBEEF : 64'h0);
      if (tbl[v].sel) check($sformatf("v%0d tready_stalled", v), stall_cycles > 0, 1);
      else            check($sformatf("v%0d tready_stalls", v), stall_cycles, 0);
    end

    // valid withdrawn during a backpressure stall
    sel = 1;
    do_reset();
    start();
    drop_pending = 1;
    send_stream(32, -1, -1);
    settle();
    check("proto stall_seen", drop_pending, 0);
    check("proto flags", flags, 5'b10000);
    check("proto error_count", ec, 1);
    check("proto frame_count", fc, 4);
    check("proto pass", pass, 0);

    // reset pulsed mid-frame, then a fresh frame from word 0
    sel = 0;
    do_reset();
    start();
    send(32'd0, 1, 0);
    send(32'd1, 0, 0);
    send(32'd2, 0, 0);
    send(32'd3, 0, 0);
    tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("midrst tready", tready, 0);
    check("midrst counts", {fc, 16'h0, ec}, 64'h0);
    repeat (2) @(posedge aclk);
    #1;
    send_stream(8, -1, -1);
    settle();
    check("midrst frame_count", fc, 1);
    check("midrst error_count", ec, 0);
    check("midrst flags", flags, 5'b00000);
    check("midrst pass", pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
